arm_mem_resp: RTL and testbench

Single-port unified memory responder that services the ARM core's instruction-fetch and data load/store requests. It arbitrates round-robin between the two request ports and performs one word access at a time. Each access completes after a configurable number of wait cycles, and completion is signalled with a one-cycle ready pulse. It sits opposite `arm_core` on the memory interface, in both the simulation top level and the FPGA top level.

---
 rtl/arm_mem_resp.sv | 196 +++++++++++++++++++
 tb/tb_arm_mem_resp.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : arm_mem_resp
// Brief    : Single-port unified memory responder for the ARM core. Round-robin
//            arbitration between instruction fetch and data load/store, one
//            word access at a time, fixed LATENCY cycles from accept to a
//            one-cycle ready pulse. Out-of-range accesses pulse err, suppress
//            stores and return zero.
// Options  : ARM_MEM_ALIGN_CHECK_EN - when defined, addr[1:0] != 0 also faults.
// Revision : 1.0 - initial release
// ============================================================================
module arm_mem_resp #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halted,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    output logic        inst_ready,
    input  logic        data_req,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out,
    output logic        data_ready,
    output logic        err
);

    localparam int         c_DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);
    localparam bit         c_LAT_ONE  = (LATENCY == 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;

    // Access captured at accept
    logic                  r_last_was_data;
    logic                  r_sel_data;
    logic                  r_we;
    logic                  r_fault;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_wdata;

    logic [31:0]           r_mem [c_DEPTH];

    logic                  w_accept;
    logic                  w_finish;
    logic                  w_pre_done;
    logic                  w_grant_data;
    logic [31:0]           w_acc_addr;
    logic [ADDR_WIDTH-1:0] w_acc_idx;
    logic                  w_acc_oor;
    logic                  w_acc_fault;
    logic                  w_cur_data;
    logic                  w_cur_we;
    logic                  w_cur_fault;
    logic [ADDR_WIDTH-1:0] w_cur_idx;
    logic [31:0]           w_rd_word;

    // Data wins when it is the only requester, or when contested and the last
    // grant went to instruction fetch (last_was_data resets to 0).
    assign w_grant_data = data_req & (~inst_req | ~r_last_was_data);
    assign w_acc_addr   = w_grant_data ? mem_addr : inst_addr;
    assign w_acc_idx    = w_acc_addr[ADDR_WIDTH+1:2];

    generate
        if (ADDR_WIDTH < 30) begin : g_range_chk
            assign w_acc_oor = |w_acc_addr[31:ADDR_WIDTH+2];
        end else begin : g_range_full
            assign w_acc_oor = 1'b0;
        end
    endgenerate

`ifdef ARM_MEM_ALIGN_CHECK_EN
    assign w_acc_fault = w_acc_oor | (|w_acc_addr[1:0]);
`else
    // Byte offset is ignored: the access goes to the containing word.
    logic w_unused_lsb;
    assign w_unused_lsb = ^w_acc_addr[1:0];
    assign w_acc_fault  = w_acc_oor;
`endif

    // Next-state logic: accept in IDLE, count down in BUSY, finish at zero
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!halted && (inst_req || data_req)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are loaded on the edge that opens the
    // completion cycle: the accept edge when LATENCY is 1, else when cnt==1.
    assign w_pre_done  = (w_accept & c_LAT_ONE) | ((r_state == S_BUSY) && (r_cnt == 4'd1));

    // With LATENCY 1 the access has not been latched yet at that edge, so take
    // the live request; otherwise use the captured access.
    assign w_cur_data  = w_accept ? w_grant_data                  : r_sel_data;
    assign w_cur_we    = w_accept ? (w_grant_data & mem_write_en) : r_we;
    assign w_cur_fault = w_accept ? w_acc_fault                   : r_fault;
    assign w_cur_idx   = w_accept ? w_acc_idx                     : r_idx;
    assign w_rd_word   = w_cur_fault ? 32'h0000_0000 : r_mem[w_cur_idx];

    // State and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the granted access and remember which port won
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_was_data <= 1'b0;
            r_sel_data      <= 1'b0;
            r_we            <= 1'b0;
            r_fault         <= 1'b0;
            r_idx           <= '0;
            r_wdata         <= 32'h0000_0000;
        end else if (w_accept) begin
            r_last_was_data <= w_grant_data;
            r_sel_data      <= w_grant_data;
            r_we            <= w_grant_data & mem_write_en;
            r_fault         <= w_acc_fault;
            r_idx           <= w_acc_idx;
            r_wdata         <= mem_data_in;
        end
    end

    // Ready/err pulses and read-data registers, one port per completion
    always_ff @(posedge clk) begin
        if (rst) begin
            inst         <= 32'h0000_0000;
            mem_data_out <= 32'h0000_0000;
            inst_ready   <= 1'b0;
            data_ready   <= 1'b0;
            err          <= 1'b0;
        end else begin
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            err        <= 1'b0;
            if (w_pre_done) begin
                err <= w_cur_fault;
                if (w_cur_data) begin
                    data_ready <= 1'b1;
                    if (!w_cur_we) begin
                        mem_data_out <= w_rd_word;
                    end
                end else begin
                    inst_ready <= 1'b1;
                    inst       <= w_rd_word;
                end
            end
        end
    end

    // Storage array, not reset; faulted stores and aborted accesses never write
    always_ff @(posedge clk) begin
        if (!rst && w_finish && r_we && !r_fault) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arm_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_mem_resp
// Brief    : Self-checking bench for arm_mem_resp against a word-array model
//            (default ADDR_WIDTH=10, LATENCY=2).
// Options  : ARM_MEM_ALIGN_CHECK_EN - changes expected misaligned behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_mem_resp;

    localparam int AW    = 10;
    localparam int L     = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        halted       = 1'b0;
    logic        inst_req     = 1'b0;
    logic [31:0] inst_addr    = 32'h0;
    logic        data_req     = 1'b0;
    logic        mem_write_en = 1'b0;
    logic [31:0] mem_addr     = 32'h0;
    logic [31:0] mem_data_in  = 32'h0;
    logic [31:0] inst;
    logic        inst_ready;
    logic [31:0] mem_data_out;
    logic        data_ready;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_inst = 32'h0;
    logic [31:0] exp_dout = 32'h0;

    arm_mem_resp #(.ADDR_WIDTH(AW), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .halted(halted),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst(inst), .inst_ready(inst_ready),
        .data_req(data_req), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .data_ready(data_ready), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic bit model_fault(input logic [31:0] a);
        bit f;
        f = (a >> (AW + 2)) != 32'd0;
`ifdef ARM_MEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) f = 1'b1;
`endif
        return f;
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic model_apply(input bit is_data, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic exp_err,
                               output logic [31:0] exp_rd);
        exp_err = model_fault(addr);
        exp_rd  = exp_err ? 32'h0 : model[model_idx(addr)];
        if (is_data && we) begin
            if (!exp_err) model[model_idx(addr)] = wdata;
        end else if (is_data) begin
            exp_dout = exp_rd;
        end else begin
            exp_inst = exp_rd;
        end
    endtask

    // ---------------- bus driver (no checking) ----------------
    task automatic drive_access(input bit is_data, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, output int lat, output logic got_err,
                                output logic [31:0] rdata, output bit wrong);
        bit done;
        done = 1'b0; lat = -1; got_err = 1'bx; rdata = 'x; wrong = 1'b0;
        @(posedge clk); #1;
        if (is_data) begin
            data_req = 1'b1; mem_write_en = we; mem_addr = addr; mem_data_in = wdata;
        end else begin
            inst_req = 1'b1; inst_addr = addr;
        end
        for (int i = 1; i <= 40 && !done; i++) begin
            @(posedge clk); #1;
            if ((is_data ? inst_ready : data_ready) === 1'b1) wrong = 1'b1;
            if ((is_data ? data_ready : inst_ready) === 1'b1) begin
                lat = i; got_err = err; rdata = is_data ? mem_data_out : inst; done = 1'b1;
            end else if (err === 1'b1) begin
                wrong = 1'b1;
            end
        end
        data_req = 1'b0; inst_req = 1'b0; mem_write_en = 1'b0;
        @(posedge clk); #1;
        if (inst_ready !== 1'b0 || data_ready !== 1'b0 || err !== 1'b0) wrong = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        bit seen;
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h expected 0", inst); end
        checks++; if (mem_data_out !== 32'h0) begin failures++; $display("FAIL reset_dout: got %h expected 0", mem_data_out); end
        checks++; if (inst_ready !== 1'b0) begin failures++; $display("FAIL reset_inst_ready: got %b expected 0", inst_ready); end
        checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL reset_data_ready: got %b expected 0", data_ready); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (inst_ready !== 1'b0 || data_ready !== 1'b0 || err !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL idle_quiet: got pulse expected none"); end
    endtask

    task automatic test_fill;
        int lat; logic e, ee; logic [31:0] rd, erd, d; bit wr;
        for (int w = 0; w < DEPTH; w++) begin
            d = $urandom;
            drive_access(1'b1, 1'b1, 32'(w * 4), d, lat, e, rd, wr);
            model_apply(1'b1, 1'b1, 32'(w * 4), d, ee, erd);
            checks++;
            if (lat != L || e !== 1'b0 || wr || mem_data_out !== exp_dout) begin
                failures++;
                $display("FAIL fill_store[%0d]: got lat=%0d err=%b wrong=%b dout=%h expected lat=%0d err=0 dout=%h",
                         w, lat, e, wr, mem_data_out, L, exp_dout);
            end
        end
    endtask

    task automatic test_fetch;
        int lat; logic e, ee; logic [31:0] rd, erd; bit wr;
        drive_access(1'b1, 1'b1, 32'h8, 32'hE3A01005, lat, e, rd, wr);
        model_apply(1'b1, 1'b1, 32'h8, 32'hE3A01005, ee, erd);
        drive_access(1'b0, 1'b0, 32'h8, 32'h0, lat, e, rd, wr);
        model_apply(1'b0, 1'b0, 32'h8, 32'h0, ee, erd);
        checks++; if (lat != L) begin failures++; $display("FAIL fetch_latency: got %0d expected %0d", lat, L); end
        checks++; if (rd !== 32'hE3A01005) begin failures++; $display("FAIL fetch_data: got %h expected e3a01005", rd); end
        checks++; if (e !== 1'b0 || wr) begin failures++; $display("FAIL fetch_flags: got err=%b wrong=%b expected 0/0", e, wr); end
    endtask

    task automatic test_store_load;
        int lat; logic e, ee; logic [31:0] rd, erd; bit wr;
        drive_access(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, lat, e, rd, wr);
        model_apply(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, ee, erd);
        checks++; if (lat != L || e !== 1'b0 || wr) begin failures++; $display("FAIL store_ready: got lat=%0d err=%b wrong=%b expected %0d/0/0", lat, e, wr, L); end
        drive_access(1'b1, 1'b0, 32'h40, 32'h0, lat, e, rd, wr);
        model_apply(1'b1, 1'b0, 32'h40, 32'h0, ee, erd);
        checks++; if (lat != L || e !== 1'b0 || wr) begin failures++; $display("FAIL load_ready: got lat=%0d err=%b wrong=%b expected %0d/0/0", lat, e, wr, L); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_after_store: got %h expected deadbeef", rd); end
    endtask

    task automatic test_fault;
        int lat; logic e, ee; logic [31:0] rd, erd; bit wr;
        drive_access(1'b1, 1'b1, 32'h1000, 32'hCAFEF00D, lat, e, rd, wr);
        model_apply(1'b1, 1'b1, 32'h1000, 32'hCAFEF00D, ee, erd);
        checks++; if (lat != L || e !== 1'b1) begin failures++; $display("FAIL fault_store: got lat=%0d err=%b expected %0d/1", lat, e, L); end
        drive_access(1'b1, 1'b0, 32'h1000, 32'h0, lat, e, rd, wr);
        model_apply(1'b1, 1'b0, 32'h1000, 32'h0, ee, erd);
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL fault_load: got err=%b data=%h expected 1/00000000", e, rd); end
        drive_access(1'b1, 1'b0, 32'h0, 32'h0, lat, e, rd, wr);
        model_apply(1'b1, 1'b0, 32'h0, 32'h0, ee, erd);
        checks++; if (rd !== erd || e !== 1'b0) begin failures++; $display("FAIL fault_store_suppressed: got %h err=%b expected %h err=0", rd, e, erd); end
        drive_access(1'b0, 1'b0, 32'h0010_0004, 32'h0, lat, e, rd, wr);
        model_apply(1'b0, 1'b0, 32'h0010_0004, 32'h0, ee, erd);
        checks++; if (e !== 1'b1 || rd !== 32'h0 || wr) begin failures++; $display("FAIL fault_fetch: got err=%b data=%h expected 1/00000000", e, rd); end
    endtask

    task automatic test_misaligned;
        int lat; logic e, ee; logic [31:0] rd, erd; bit wr;
        drive_access(1'b1, 1'b1, 32'h40, 32'h12345678, lat, e, rd, wr);
        model_apply(1'b1, 1'b1, 32'h40, 32'h12345678, ee, erd);
        drive_access(1'b1, 1'b0, 32'h41, 32'h0, lat, e, rd, wr);
        model_apply(1'b1, 1'b0, 32'h41, 32'h0, ee, erd);
`ifdef ARM_MEM_ALIGN_CHECK_EN
        checks++; if (rd !== 32'h0 || e !== 1'b1) begin failures++; $display("FAIL misaligned_load: got %h err=%b expected 00000000 err=1", rd, e); end
`else
        checks++; if (rd !== 32'h12345678 || e !== 1'b0) begin failures++; $display("FAIL misaligned_load: got %h err=%b expected 12345678 err=0", rd, e); end
`endif
        checks++; if (lat != L || wr) begin failures++; $display("FAIL misaligned_timing: got lat=%0d wrong=%b expected %0d/0", lat, wr, L); end
    endtask

    task automatic test_random;
        int lat; logic e, ee; logic [31:0] rd, erd, a, d; bit wr, is_d, we; int r;
        for (int n = 0; n < 300; n++) begin
            is_d = ($urandom_range(0, 2) != 0);
            we   = is_d && ($urandom_range(0, 1) == 1);
            r    = $urandom_range(0, 9);
            a    = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
            if (r == 0) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
            if (r == 1) a[1:0]   = 2'($urandom_range(1, 3));
            d = $urandom;
            drive_access(is_d, we, a, d, lat, e, rd, wr);
            model_apply(is_d, we, a, d, ee, erd);
            checks++; if (lat != L) begin failures++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, lat, L); end
            checks++; if (e !== ee) begin failures++; $display("FAIL rnd_err[%0d] addr=%h: got %b expected %b", n, a, e, ee); end
            checks++; if (wr) begin failures++; $display("FAIL rnd_port[%0d]: got stray pulse expected none", n); end
            if (!(is_d && we)) begin
                checks++; if (rd !== erd) begin failures++; $display("FAIL rnd_rdata[%0d] addr=%h: got %h expected %h", n, a, rd, erd); end
            end
            checks++;
            if (inst !== exp_inst || mem_data_out !== exp_dout) begin
                failures++;
                $display("FAIL rnd_hold[%0d]: got inst=%h dout=%h expected inst=%h dout=%h", n, inst, mem_data_out, exp_inst, exp_dout);
            end
        end
    endtask

    task automatic test_halted;
        bit seen; int lat;
        @(posedge clk); #1;
        halted = 1'b1; data_req = 1'b1; mem_write_en = 1'b0; mem_addr = 32'h44;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (data_ready !== 1'b0 || inst_ready !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL halted_block: got ready expected none"); end
        halted = 1'b0; lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (data_ready === 1'b1) lat = i;
        end
        data_req = 1'b0;
        exp_dout = model[32'h44 >> 2];
        checks++; if (lat != L || mem_data_out !== exp_dout) begin failures++; $display("FAIL halted_release: got lat=%0d data=%h expected %0d/%h", lat, mem_data_out, L, exp_dout); end
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'h8; lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (inst_ready === 1'b1) lat = i;
            if (i == 1) halted = 1'b1;
        end
        inst_req = 1'b0;
        exp_inst = model[2];
        checks++; if (lat != L || inst !== exp_inst) begin failures++; $display("FAIL halted_in_busy: got lat=%0d inst=%h expected %0d/%h", lat, inst, L, exp_inst); end
        @(posedge clk); #1; halted = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit seen; logic [31:0] old; int lat; logic e, ee; logic [31:0] rd, erd; bit wr;
        old = model[32'h80 >> 2];
        @(posedge clk); #1;
        data_req = 1'b1; mem_write_en = 1'b1; mem_addr = 32'h80; mem_data_in = ~old;
        @(posedge clk); #1;
        rst = 1'b1; data_req = 1'b0; mem_write_en = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (data_ready !== 1'b0) seen = 1'b1; end
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (data_ready !== 1'b0) seen = 1'b1; end
        exp_inst = 32'h0; exp_dout = 32'h0;
        checks++; if (seen) begin failures++; $display("FAIL reset_abort_ready: got pulse expected none"); end
        checks++; if (mem_data_out !== 32'h0) begin failures++; $display("FAIL reset_abort_dout: got %h expected 0", mem_data_out); end
        drive_access(1'b1, 1'b0, 32'h80, 32'h0, lat, e, rd, wr);
        model_apply(1'b1, 1'b0, 32'h80, 32'h0, ee, erd);
        checks++; if (rd !== old || e !== 1'b0) begin failures++; $display("FAIL reset_abort_nowrite: got %h err=%b expected %h err=0", rd, e, old); end
    endtask

    task automatic test_contention;
        int start, got; int t [4]; bit p [4]; logic [31:0] v [4]; logic ev [4];
        int exp_t; bit exp_p; logic [31:0] exp_v;
        rst = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h8;
        data_req = 1'b1; mem_write_en = 1'b0; mem_addr = 32'h40;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0; start = cyc; got = 0;
        for (int i = 0; i < 40 && got < 4; i++) begin
            @(posedge clk); #1;
            if (data_ready === 1'b1 || inst_ready === 1'b1) begin
                t[got] = cyc - start; p[got] = (data_ready === 1'b1);
                v[got] = (data_ready === 1'b1) ? mem_data_out : inst; ev[got] = err;
                if (data_ready === 1'b1 && inst_ready === 1'b1) v[got] = 'x;
                got++;
            end
        end
        inst_req = 1'b0; data_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (got != 4) begin failures++; $display("FAIL contention_count: got %0d expected 4", got); end
        for (int k = 0; k < got; k++) begin
            exp_p = (k % 2 == 0);
            exp_t = L + k * (L + 1);
            exp_v = exp_p ? model[32'h40 >> 2] : model[2];
            checks++;
            if (p[k] !== exp_p || t[k] != exp_t || v[k] !== exp_v || ev[k] !== 1'b0) begin
                failures++;
                $display("FAIL contention[%0d]: got data=%b t=%0d v=%h err=%b expected data=%b t=%0d v=%h err=0",
                         k, p[k], t[k], v[k], ev[k], exp_p, exp_t, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset;
        test_fill;
        test_fetch;
        test_store_load;
        test_fault;
        test_misaligned;
        test_random;
        test_halted;
        test_reset_mid;
        test_contention;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
